// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes, field
// positions and the per-opcode control bundle.
package id_pkg;

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_ADDI = 6'd3,
    OP_LD   = 6'd4,
    OP_ST   = 6'd5,
    OP_BEZ  = 6'd6
  } opcodeE;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int DEST_HI = 25;
  localparam int DEST_LO = 21;
  localparam int SRC1_HI = 20;
  localparam int SRC1_LO = 16;
  localparam int SRC2_HI = 15;
  localparam int SRC2_LO = 11;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  typedef struct packed {
    opcodeE op;
    logic   valid;
    logic   useSrc1;
    logic   useSrc2;
    logic   memRead;
    logic   memWrite;
    logic   wbEn;
    logic   isBranch;
  } ctrlS;

  // Unknown opcodes fall through to an all-zero NOP bundle.
  function automatic ctrlS decodeCtrl(input logic [5:0] raw);
    ctrlS c;
    c = '{op: OP_NOP, default: 1'b0};
    case (raw)
      OP_ADD:  begin c.op = OP_ADD;  c.valid = 1'b1; c.useSrc1 = 1'b1; c.useSrc2 = 1'b1; c.wbEn = 1'b1; end
      OP_SUB:  begin c.op = OP_SUB;  c.valid = 1'b1; c.useSrc1 = 1'b1; c.useSrc2 = 1'b1; c.wbEn = 1'b1; end
      OP_ADDI: begin c.op = OP_ADDI; c.valid = 1'b1; c.useSrc1 = 1'b1; c.wbEn = 1'b1; end
      OP_LD:   begin c.op = OP_LD;   c.valid = 1'b1; c.useSrc1 = 1'b1; c.wbEn = 1'b1; c.memRead = 1'b1; end
      OP_ST:   begin c.op = OP_ST;   c.valid = 1'b1; c.useSrc1 = 1'b1; c.useSrc2 = 1'b1; c.memWrite = 1'b1; end
      OP_BEZ:  begin c.op = OP_BEZ;  c.valid = 1'b1; c.useSrc1 = 1'b1; c.isBranch = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous read ports with write-through from the
// single write port; R0 is hard-wired to zero.
module regfile
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  rdAddr1,
  input  logic [4:0]  rdAddr2,
  output logic [31:0] rdData1,
  output logic [31:0] rdData2,
  input  logic        wrEn,
  input  logic [4:0]  wrAddr,
  input  logic [31:0] wrData
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wrEn && wrAddr != 5'd0) begin
      regs[wrAddr] <= wrData;
    end
  end

  // A same-cycle write forwards its data so decode never sees a stale value.
  assign rdData1 = (rdAddr1 == 5'd0) ? 32'd0 :
                   (wrEn && wrAddr == rdAddr1) ? wrData : regs[rdAddr1];
  assign rdData2 = (rdAddr2 == 5'd0) ? 32'd0 :
                   (wrEn && wrAddr == rdAddr2) ? wrData : regs[rdAddr2];

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, decode, register read, load-use
// hazard detection, BEZ branch resolution and the ID/EX pipeline register.
module id_stage
  import id_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] PC,
  input  logic [31:0] instruction,
  input  logic        exMemRead,
  input  logic [4:0]  exDest,
  input  logic        wbEn,
  input  logic [4:0]  wbDest,
  input  logic [31:0] wbData,
  output logic        freeze,
  output logic        brTaken,
  output logic [31:0] brOffset,
  output logic        idexValid,
  output logic [31:0] idexPC,
  output logic [5:0]  idexOpcode,
  output logic [4:0]  idexDest,
  output logic [4:0]  idexSrc1,
  output logic [4:0]  idexSrc2,
  output logic [31:0] idexVal1,
  output logic [31:0] idexVal2,
  output logic [31:0] idexImm,
  output logic        idexMemRead,
  output logic        idexMemWrite,
  output logic        idexWbEn
);

  logic [31:0] ifPC;
  logic [31:0] ifInstr;
  logic        ifValid;

  logic [4:0]  dest;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [31:0] immExt;
  logic [31:0] val1;
  logic [31:0] val2;
  ctrlS        ctrl;
  logic        hazard;

  // Stall handshake: while freeze is high the fetch stage holds PC/instruction,
  // the IF/ID latch holds, and ID/EX takes a bubble; nothing is lost or repeated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifPC    <= 32'd0;
      ifInstr <= NOP_WORD;
      ifValid <= 1'b0;
    end else if (freeze) begin
      ifPC    <= ifPC;
      ifInstr <= ifInstr;
      ifValid <= ifValid;
    end else if (brTaken) begin
      ifPC    <= PC;
      ifInstr <= NOP_WORD;
      ifValid <= 1'b0;
    end else begin
      ifPC    <= PC;
      ifInstr <= instruction;
      ifValid <= 1'b1;
    end
  end

  always_comb begin
    dest   = ifInstr[DEST_HI:DEST_LO];
    src1   = ifInstr[SRC1_HI:SRC1_LO];
    src2   = ifInstr[SRC2_HI:SRC2_LO];
    immExt = {{16{ifInstr[IMM_HI]}}, ifInstr[IMM_HI:IMM_LO]};
    ctrl   = decodeCtrl(ifInstr[OPC_HI:OPC_LO]);
  end

  regfile uRegfile (
    .clk     (clk),
    .rstn    (rstn),
    .rdAddr1 (src1),
    .rdAddr2 (src2),
    .rdData1 (val1),
    .rdData2 (val2),
    .wrEn    (wbEn),
    .wrAddr  (wbDest),
    .wrData  (wbData)
  );

  // Only operands the opcode really reads can create a load-use stall.
  always_comb begin
    hazard = 1'b0;
    if (ifValid && exMemRead && exDest != 5'd0) begin
      hazard = (ctrl.useSrc1 && exDest == src1) || (ctrl.useSrc2 && exDest == src2);
    end
    freeze   = hazard;
    brTaken  = ifValid && ctrl.isBranch && (val1 == 32'd0) && !hazard;
    brOffset = brTaken ? immExt : 32'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || freeze) begin
      idexValid    <= 1'b0;
      idexPC       <= 32'd0;
      idexOpcode   <= 6'd0;
      idexDest     <= 5'd0;
      idexSrc1     <= 5'd0;
      idexSrc2     <= 5'd0;
      idexVal1     <= 32'd0;
      idexVal2     <= 32'd0;
      idexImm      <= 32'd0;
      idexMemRead  <= 1'b0;
      idexMemWrite <= 1'b0;
      idexWbEn     <= 1'b0;
    end else begin
      idexValid    <= ifValid && ctrl.valid;
      idexPC       <= ifPC;
      idexOpcode   <= ctrl.op;
      idexDest     <= dest;
      idexSrc1     <= src1;
      idexSrc2     <= src2;
      idexVal1     <= val1;
      idexVal2     <= val2;
      idexImm      <= immExt;
      idexMemRead  <= ifValid && ctrl.memRead;
      idexMemWrite <= ifValid && ctrl.memWrite;
      idexWbEn     <= ifValid && ctrl.wbEn && (dest != 5'd0);
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a cycle-by-cycle vector table plus hand-written
// sequences for freeze-vs-branch priority and reset in the middle of a stall.
module tb_id_stage;

  logic        clk;
  logic        rstn;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        exMemRead;
  logic [4:0]  exDest;
  logic        wbEn;
  logic [4:0]  wbDest;
  logic [31:0] wbData;
  logic        freeze;
  logic        brTaken;
  logic [31:0] brOffset;
  logic        idexValid;
  logic [31:0] idexPC;
  logic [5:0]  idexOpcode;
  logic [4:0]  idexDest;
  logic [4:0]  idexSrc1;
  logic [4:0]  idexSrc2;
  logic [31:0] idexVal1;
  logic [31:0] idexVal2;
  logic [31:0] idexImm;
  logic        idexMemRead;
  logic        idexMemWrite;
  logic        idexWbEn;

  int testsRun = 0;
  int failures = 0;

  id_stage #(.NOP_WORD(32'h0000_0000)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .PC           (PC),
    .instruction  (instruction),
    .exMemRead    (exMemRead),
    .exDest       (exDest),
    .wbEn         (wbEn),
    .wbDest       (wbDest),
    .wbData       (wbData),
    .freeze       (freeze),
    .brTaken      (brTaken),
    .brOffset     (brOffset),
    .idexValid    (idexValid),
    .idexPC       (idexPC),
    .idexOpcode   (idexOpcode),
    .idexDest     (idexDest),
    .idexSrc1     (idexSrc1),
    .idexSrc2     (idexSrc2),
    .idexVal1     (idexVal1),
    .idexVal2     (idexVal2),
    .idexImm      (idexImm),
    .idexMemRead  (idexMemRead),
    .idexMemWrite (idexMemWrite),
    .idexWbEn     (idexWbEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exMr;
    logic [4:0]  exD;
    logic        wbE;
    logic [4:0]  wbD;
    logic [31:0] wbV;
    logic        fr;
    logic        br;
    logic [31:0] off;
    logic        v;
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [2:0]  ctl;
    logic [31:0] epc;
    logic        ckPc;
    logic        ckVal;
    logic        ckOp;
  } vecT;

  vecT vecs[18];

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [15:0] imm);
    return {op, d, s1, imm};
  endfunction

  function automatic vecT mk(
    input logic [31:0] pc, input logic [31:0] instr, input logic exMr, input logic [4:0] exD,
    input logic wbE, input logic [4:0] wbD, input logic [31:0] wbV,
    input logic fr, input logic br, input logic [31:0] off,
    input logic v, input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
    input logic [31:0] imm, input logic [2:0] ctl, input logic [31:0] epc,
    input logic ckPc, input logic ckVal, input logic ckOp);
    vecT r;
    r.pc = pc; r.instr = instr; r.exMr = exMr; r.exD = exD;
    r.wbE = wbE; r.wbD = wbD; r.wbV = wbV;
    r.fr = fr; r.br = br; r.off = off;
    r.v = v; r.op = op; r.v1 = v1; r.v2 = v2; r.imm = imm; r.ctl = ctl; r.epc = epc;
    r.ckPc = ckPc; r.ckVal = ckVal; r.ckOp = ckOp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic exMr,
                       input logic [4:0] exD, input logic wbE, input logic [4:0] wbD,
                       input logic [31:0] wbV);
    PC = pc; instruction = instr; exMemRead = exMr; exDest = exD;
    wbEn = wbE; wbDest = wbD; wbData = wbV;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);

    // pc, instr, exMr, exD, wbE, wbD, wbV | fr, br, off | v, op, v1, v2, imm, ctl{mr,mw,wb}, epc | ckPc, ckVal, ckOp
    vecs[0]  = mk(32'h100, enc(6'd3, 5'd3, 5'd0, 16'hFFFB), 0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h0,        0, 6'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,   1, 1, 1);
    vecs[1]  = mk(32'h104, enc(6'd1, 5'd4, 5'd3, 16'h1800), 0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h0,        1, 6'd3, 32'h0,        32'h0,        32'hFFFFFFFB, 3'b001, 32'h100, 1, 1, 1);
    vecs[2]  = mk(32'h108, 32'h0,                           0, 5'd0, 1, 5'd3, 32'hFFFFFFFB, 0, 0, 32'h0,        1, 6'd1, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h1800,     3'b001, 32'h104, 1, 1, 1);
    vecs[3]  = mk(32'h10C, enc(6'd1, 5'd6, 5'd5, 16'h0800), 0, 5'd0, 1, 5'd1, 32'h11,       0, 0, 32'h0,        0, 6'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h108, 1, 1, 1);
    vecs[4]  = mk(32'h110, enc(6'd2, 5'd7, 5'd3, 16'h0800), 1, 5'd5, 0, 5'd0, 32'h0,        1, 0, 32'h0,        0, 6'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,   0, 0, 0);
    vecs[5]  = mk(32'h110, enc(6'd2, 5'd7, 5'd3, 16'h0800), 0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h0,        1, 6'd1, 32'h0,        32'h11,       32'h0800,     3'b001, 32'h10C, 1, 1, 1);
    vecs[6]  = mk(32'h114, enc(6'd3, 5'd8, 5'd0, 16'h0001), 0, 5'd3, 0, 5'd0, 32'h0,        0, 0, 32'h0,        1, 6'd2, 32'hFFFFFFFB, 32'h11,       32'h0800,     3'b001, 32'h110, 1, 1, 1);
    vecs[7]  = mk(32'h118, enc(6'd6, 5'd0, 5'd2, 16'hFFFD), 0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h0,        1, 6'd3, 32'h0,        32'h0,        32'h1,        3'b001, 32'h114, 1, 1, 1);
    vecs[8]  = mk(32'h11C, enc(6'd1, 5'd9, 5'd1, 16'h0800), 0, 5'd0, 0, 5'd0, 32'h0,        0, 1, 32'hFFFFFFFD, 1, 6'd6, 32'h0,        32'h0,        32'hFFFFFFFD, 3'b000, 32'h118, 1, 1, 1);
    vecs[9]  = mk(32'h200, enc(6'd6, 5'd0, 5'd2, 16'hFFFD), 0, 5'd0, 1, 5'd2, 32'h7,        0, 0, 32'h0,        0, 6'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,   0, 1, 1);
    vecs[10] = mk(32'h204, 32'h0,                           0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h0,        1, 6'd6, 32'h7,        32'h0,        32'hFFFFFFFD, 3'b000, 32'h200, 1, 1, 1);
    vecs[11] = mk(32'h208, enc(6'd4, 5'd10, 5'd1, 16'h0004), 0, 5'd0, 1, 5'd0, 32'hDEADBEEF, 0, 0, 32'h0,       0, 6'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h204, 1, 1, 1);
    vecs[12] = mk(32'h20C, enc(6'd5, 5'd0, 5'd2, 16'h0800), 1, 5'd9, 0, 5'd0, 32'h0,        0, 0, 32'h0,        1, 6'd4, 32'h11,       32'h0,        32'h4,        3'b101, 32'h208, 1, 1, 1);
    vecs[13] = mk(32'h210, 32'h0,                           1, 5'd1, 0, 5'd0, 32'h0,        1, 0, 32'h0,        0, 6'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,   0, 0, 0);
    vecs[14] = mk(32'h210, 32'h0,                           0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h0,        1, 6'd5, 32'h7,        32'h11,       32'h0800,     3'b010, 32'h20C, 1, 1, 1);
    vecs[15] = mk(32'h214, enc(6'h3F, 5'd5, 5'd1, 16'h0000), 0, 5'd0, 0, 5'd0, 32'h0,       0, 0, 32'h0,        0, 6'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h210, 1, 1, 1);
    vecs[16] = mk(32'h218, enc(6'd1, 5'd11, 5'd0, 16'h0000), 1, 5'd1, 0, 5'd0, 32'h0,       0, 0, 32'h0,        0, 6'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h214, 1, 0, 0);
    vecs[17] = mk(32'h21C, 32'h0,                           0, 5'd0, 1, 5'd0, 32'hDEADBEEF, 0, 0, 32'h0,        1, 6'd1, 32'h0,        32'h0,        32'h0,        3'b001, 32'h218, 1, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_idexValid", {31'd0, idexValid}, 32'd0);
    chk("reset_freeze", {31'd0, freeze}, 32'd0);
    chk("reset_brTaken", {31'd0, brTaken}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].pc, vecs[i].instr, vecs[i].exMr, vecs[i].exD, vecs[i].wbE, vecs[i].wbD, vecs[i].wbV);
      @(negedge clk);
      chk($sformatf("v%0d_freeze", i), {31'd0, freeze}, {31'd0, vecs[i].fr});
      chk($sformatf("v%0d_brTaken", i), {31'd0, brTaken}, {31'd0, vecs[i].br});
      chk($sformatf("v%0d_brOffset", i), brOffset, vecs[i].off);
      stepEdge();
      chk($sformatf("v%0d_idexValid", i), {31'd0, idexValid}, {31'd0, vecs[i].v});
      chk($sformatf("v%0d_idexCtl", i), {29'd0, idexMemRead, idexMemWrite, idexWbEn}, {29'd0, vecs[i].ctl});
      if (vecs[i].ckOp) begin
        chk($sformatf("v%0d_idexOpcode", i), {26'd0, idexOpcode}, {26'd0, vecs[i].op});
        chk($sformatf("v%0d_idexImm", i), idexImm, vecs[i].imm);
      end
      if (vecs[i].ckVal) begin
        chk($sformatf("v%0d_idexVal1", i), idexVal1, vecs[i].v1);
        chk($sformatf("v%0d_idexVal2", i), idexVal2, vecs[i].v2);
      end
      if (vecs[i].ckPc) chk($sformatf("v%0d_idexPC", i), idexPC, vecs[i].epc);
    end

    // Branch waits behind a load-use stall on its own operand, then resolves.
    drive(32'h300, enc(6'd6, 5'd0, 5'd12, 16'h0002), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    stepEdge();
    drive(32'h304, 32'h0, 1'b1, 5'd12, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("prio_freeze", {31'd0, freeze}, 32'd1);
    chk("prio_brTaken_held", {31'd0, brTaken}, 32'd0);
    stepEdge();
    drive(32'h304, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("prio_freeze_clear", {31'd0, freeze}, 32'd0);
    chk("prio_brTaken", {31'd0, brTaken}, 32'd1);
    chk("prio_brOffset", brOffset, 32'h2);
    stepEdge();
    chk("prio_bez_valid", {31'd0, idexValid}, 32'd1);
    chk("prio_bez_wbEn", {31'd0, idexWbEn}, 32'd0);

    // Reset asserted in the middle of a stall.
    drive(32'h400, enc(6'd1, 5'd6, 5'd5, 16'h0800), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    stepEdge();
    drive(32'h404, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("midrst_pre_freeze", {31'd0, freeze}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_freeze", {31'd0, freeze}, 32'd0);
    chk("midrst_brTaken", {31'd0, brTaken}, 32'd0);
    chk("midrst_idexValid", {31'd0, idexValid}, 32'd0);
    chk("midrst_idexPC", idexPC, 32'd0);
    chk("midrst_idexVal1", idexVal1, 32'd0);
    chk("midrst_idexOpcode", {26'd0, idexOpcode}, 32'd0);
    stepEdge();
    rstn = 1'b1;

    // Every register reads zero after reset; the first post-reset instruction
    // is captured at the first rising edge.
    for (int k = 1; k <= 32; k++) begin
      if (k <= 31) drive(32'(k * 4), enc(6'd1, 5'd0, 5'(k), {5'(k), 11'd0}), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      else         drive(32'h1000, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      stepEdge();
      if (k >= 2) begin
        chk($sformatf("clr_r%0d_valid", k - 1), {31'd0, idexValid}, 32'd1);
        chk($sformatf("clr_r%0d_val1", k - 1), idexVal1, 32'd0);
        chk($sformatf("clr_r%0d_val2", k - 1), idexVal2, 32'd0);
        chk($sformatf("clr_r%0d_pc", k - 1), idexPC, 32'((k - 1) * 4));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
